// File: rtl/fetch_queue.sv
// Instruction fetch request generator with in-order response queue.
// Define FETCH_QUEUE_BYPASS_EN to present a response directly when the queue is empty.
module fetch_queue #(
   parameter int                 DATA_W   = 32,
   parameter int                 ADDR_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                        clock,
   input  logic                        reset,
   output logic                        imem_req,
   output logic [ADDR_W-1:0]           imem_addr,
   input  logic [DATA_W-1:0]           imem_rdata,
   input  logic                        stall,
   input  logic                        redirect,
   input  logic [ADDR_W-1:0]           redirect_pc,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_instr,
   output logic [ADDR_W-1:0]           out_pcplus4,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_ppc4;
   logic              r_pend;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [DATA_W-1:0] r_instr [DEPTH];
   logic [ADDR_W-1:0] r_pc4   [DEPTH];

   logic [CW-1:0]     w_occ;
   logic              w_qval;
   logic              w_push;
   logic              w_popq;

   // Slots reserved for in-flight responses count against capacity.
   assign w_occ     = r_cnt + {{(CW-1){1'b0}}, r_pend};
   assign imem_req  = reset & ~redirect & (w_occ < CW'(DEPTH));
   assign imem_addr = r_pc;
   assign count     = r_cnt;
   assign w_qval    = (r_cnt != '0);
   assign w_popq    = w_qval & ~stall;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic w_byp;

   assign w_byp     = ~w_qval & r_pend;
   assign out_valid = w_qval | r_pend;
   assign w_push    = r_pend & ~(w_byp & ~stall);

   always_comb begin
      out_instr   = '0;
      out_pcplus4 = '0;
      if (w_qval) begin
         out_instr   = r_instr[r_rptr];
         out_pcplus4 = r_pc4[r_rptr];
      end else if (w_byp) begin
         out_instr   = imem_rdata;
         out_pcplus4 = r_ppc4;
      end
   end
`else
   assign out_valid = w_qval;
   assign w_push    = r_pend;

   always_comb begin
      out_instr   = '0;
      out_pcplus4 = '0;
      if (w_qval) begin
         out_instr   = r_instr[r_rptr];
         out_pcplus4 = r_pc4[r_rptr];
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc   <= RESET_PC;
         r_ppc4 <= '0;
         r_pend <= 1'b0;
         r_cnt  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (redirect) begin
         r_pc   <= redirect_pc;
         r_pend <= 1'b0;
         r_cnt  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         r_pend <= imem_req;
         if (imem_req) begin
            r_pc   <= r_pc + ADDR_W'(4);
            r_ppc4 <= r_pc + ADDR_W'(4);
         end
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_popq) r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_popq})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push && !redirect) begin
         r_instr[r_wptr] <= imem_rdata;
         r_pc4[r_wptr]   <= r_ppc4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: memory returns addr>>2 one cycle after a request.
module tb_fetch_queue;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;
   localparam logic [ADDR_W-1:0] RST_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pcplus4;
   logic [$clog2(DEPTH):0] count;

   fetch_queue #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)
   ) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr),
      .out_pcplus4(out_pcplus4), .count(count)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      imem_rdata <= imem_req ? DATA_W'(imem_addr >> 2) : 32'hDEAD_BEEF;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic [DATA_W+ADDR_W-1:0] sb[$];
   logic [DATA_W+ADDR_W-1:0] e;
   logic [ADDR_W-1:0]        exp_pc;
   int                       pend_m;
   int                       qcnt;
   bit                       exp_v;

   always @(negedge clock) begin
      if (!reset) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_req", imem_req, 0);
         chk("rst_count", count, 0);
         chk("rst_instr", out_instr, 0);
         chk("rst_pc4", out_pcplus4, 0);
         sb.delete();
         pend_m = 0;
         exp_pc = RST_PC;
      end else begin
         qcnt = sb.size() - pend_m;
         chk("count", count, qcnt);
         chk("req", imem_req, (!redirect && sb.size() < DEPTH) ? 1 : 0);
         if (imem_req) chk("addr", imem_addr, exp_pc);
`ifdef FETCH_QUEUE_BYPASS_EN
         exp_v = (qcnt > 0) || (pend_m != 0);
`else
         exp_v = (qcnt > 0);
`endif
         chk("valid", out_valid, exp_v);
         if (out_valid && sb.size() > 0) begin
            e = sb[0];
            chk("instr", out_instr, e[DATA_W+ADDR_W-1:ADDR_W]);
            chk("pc4", out_pcplus4, e[ADDR_W-1:0]);
         end
         if (redirect) begin
            sb.delete();
            pend_m = 0;
            exp_pc = redirect_pc;
         end else begin
            if (out_valid && !stall && sb.size() > 0) e = sb.pop_front();
            if (imem_req) begin
               sb.push_back({DATA_W'(exp_pc >> 2), exp_pc + 32'd4});
               exp_pc = exp_pc + 32'd4;
            end
            pend_m = imem_req ? 1 : 0;
         end
      end
   end

   task automatic wait_count(input int n, input string tag);
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         if (count == n) return;
      end
      chk(tag, count, n);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      cycles(3);
      reset = 1'b1; #1;
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, RST_PC);
      @(posedge clock); #1;
      chk("lat_c1_valid", out_valid, (LAT == 1) ? 1 : 0);
      @(posedge clock); #1;
      chk("lat_c2_valid", out_valid, 1);
      chk("lat_c2_instr", out_instr, 2 - LAT);
      @(posedge clock); #1;
      chk("lat_c3_instr", out_instr, 3 - LAT);
      cycles(8);

      stall = 1'b1;
      cycles(8);
      chk("stall_full", count, DEPTH);
      chk("stall_req", imem_req, 0);
      stall = 1'b0;
      cycles(6);

      for (int i = 0; i < 40; i++) begin
         stall = ($urandom_range(0, 2) == 0);
         cycles(1);
      end

      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      cycles(1);
      redirect = 1'b0;
      wait_count(3, "wait_cnt3_timeout");
      chk("pre_redir_count", count, 3);
      redirect = 1'b1; redirect_pc = 32'h100;
      cycles(1);
      redirect = 1'b0; #1;
      chk("redir_count", count, 0);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_req", imem_req, 1);
      stall = 1'b0;
      cycles(10);

      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cycles(1);
      redirect = 1'b0;
      cycles(2);
      chk("wrap_addr", imem_addr, 32'h0);
      cycles(8);

      stall = 1'b1;
      wait_count(2, "wait_cnt2_timeout");
      reset = 1'b0; #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_count", count, 0);
      cycles(1);
      reset = 1'b1; stall = 1'b0; #1;
      chk("rel_addr", imem_addr, RST_PC);
      chk("rel_req", imem_req, 1);
      cycles(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
